// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types for the RV32 M-extension multiply/divide unit (FSM states, funct3 codes).
// Optional single-cycle multiply is selected with MULDIV_FAST_MUL_EN.
package loopyV_data_types;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_MUL,
      MD_DIV,
      MD_DONE
   } muldivStateType;

   localparam logic [2:0] MD_FUNCT3_MUL    = 3'd0;
   localparam logic [2:0] MD_FUNCT3_MULH   = 3'd1;
   localparam logic [2:0] MD_FUNCT3_MULHSU = 3'd2;
   localparam logic [2:0] MD_FUNCT3_MULHU  = 3'd3;
   localparam logic [2:0] MD_FUNCT3_DIV    = 3'd4;
   localparam logic [2:0] MD_FUNCT3_DIVU   = 3'd5;
   localparam logic [2:0] MD_FUNCT3_REM    = 3'd6;
   localparam logic [2:0] MD_FUNCT3_REMU   = 3'd7;

   // Magnitude of a possibly-signed word; 0x80000000 maps to itself, read as unsigned.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? -v : v;
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline and the multiply/divide unit.
interface ex_muldiv_unit_if;

   logic        startEX;
   logic [2:0]  funct3EX;
   logic [31:0] operandAEX;
   logic [31:0] operandBEX;
   logic        flushEX;
   logic        busyEX;
   logic        doneEX;
   logic [31:0] resultEX;

   modport master (
      output startEX, funct3EX, operandAEX, operandBEX, flushEX,
      input  busyEX, doneEX, resultEX
   );

   modport slave (
      input  startEX, funct3EX, operandAEX, operandBEX, flushEX,
      output busyEX, doneEX, resultEX
   );

endinterface

// File: rtl/ex_muldiv_unit_div_step.sv
// One combinational restoring-divide step: shift in the next dividend bit, subtract if it fits.
module muldiv_div_step (
   input  logic [32:0] rem,
   input  logic [31:0] quo,
   input  logic [31:0] divisor,
   output logic [32:0] rem_next,
   output logic [31:0] quo_next
);

   logic [33:0] shifted;
   logic [34:0] diff;

   always_comb begin
      shifted = {rem, quo[31]};
      diff    = {1'b0, shifted} - {3'b000, divisor};
      // A clear sign bit means the divisor fit: keep the difference, emit a 1.
      if (!diff[34]) begin
         rem_next = diff[32:0];
         quo_next = {quo[30:0], 1'b1};
      end else begin
         rem_next = shifted[32:0];
         quo_next = {quo[30:0], 1'b0};
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32 M multiply/divide unit for the EX stage: 32-cycle shift-add / restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
module ex_muldiv_unit
   import loopyV_data_types::*;
(
   input logic           clk,
   input logic           arstn,
   ex_muldiv_unit_if.slave md
);

   muldivStateType state, state_n;
   logic [2:0]  op, op_n;
   logic        neg, neg_n;
   logic [4:0]  cnt, cnt_n;
   logic [31:0] opnd, opnd_n;
   logic [63:0] prod, prod_n;
   logic [32:0] rem, rem_n;
   logic [31:0] quo, quo_n;
   logic [31:0] result_q, result_n;

   logic        sgn_a, sgn_b, div_by_zero, div_ovf, neg_in;
   logic [31:0] abs_a, abs_b;
   logic [32:0] mul_sum, step_rem;
   logic [31:0] step_quo, quo_f, rem_f;
   logic [63:0] prod_f;
`ifdef MULDIV_FAST_MUL_EN
   logic [63:0] fast_a, fast_b, fast_prod;
`endif

   muldiv_div_step u_div_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (opnd),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   always_comb begin
      sgn_a  = md.funct3EX inside {MD_FUNCT3_MULH, MD_FUNCT3_MULHSU, MD_FUNCT3_DIV, MD_FUNCT3_REM};
      sgn_b  = md.funct3EX inside {MD_FUNCT3_MULH, MD_FUNCT3_DIV, MD_FUNCT3_REM};
      abs_a  = abs32(md.operandAEX, sgn_a);
      abs_b  = abs32(md.operandBEX, sgn_b);
      // Remainder follows the dividend; everything else follows the product/quotient sign.
      neg_in = (md.funct3EX == MD_FUNCT3_REM) ? md.operandAEX[31]
             : (sgn_a & md.operandAEX[31]) ^ (sgn_b & md.operandBEX[31]);
      div_by_zero = (md.operandBEX == 32'd0);
      div_ovf     = sgn_b && (md.operandAEX == 32'h8000_0000) && (md.operandBEX == 32'hFFFF_FFFF);
      mul_sum     = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);
`ifdef MULDIV_FAST_MUL_EN
      fast_a    = {{32{sgn_a & md.operandAEX[31]}}, md.operandAEX};
      fast_b    = {{32{sgn_b & md.operandBEX[31]}}, md.operandBEX};
      fast_prod = fast_a * fast_b;
`endif
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_n = state;
      op_n    = op;
      neg_n   = neg;
      cnt_n   = cnt;
      opnd_n  = opnd;
      prod_n  = prod;
      rem_n   = rem;
      quo_n   = quo;
      case (state)
         MD_IDLE: if (md.startEX) begin
            op_n  = md.funct3EX;
            neg_n = neg_in;
            cnt_n = 5'd0;
            if (!md.funct3EX[2]) begin
`ifdef MULDIV_FAST_MUL_EN
               prod_n  = fast_prod;
               neg_n   = 1'b0;
               state_n = MD_DONE;
`else
               opnd_n  = abs_a;
               prod_n  = {32'd0, abs_b};
               state_n = MD_MUL;
`endif
            end else if (div_by_zero) begin
               quo_n   = 32'hFFFF_FFFF;
               rem_n   = {1'b0, md.operandAEX};
               neg_n   = 1'b0;
               state_n = MD_DONE;
            end else if (div_ovf) begin
               quo_n   = 32'h8000_0000;
               rem_n   = 33'd0;
               neg_n   = 1'b0;
               state_n = MD_DONE;
            end else begin
               opnd_n  = abs_b;
               quo_n   = abs_a;
               rem_n   = 33'd0;
               state_n = MD_DIV;
            end
         end
         MD_MUL: begin
            prod_n = {mul_sum, prod[31:1]};
            cnt_n  = cnt + 5'd1;
            if (cnt == 5'd31) state_n = MD_DONE;
         end
         MD_DIV: begin
            rem_n = step_rem;
            quo_n = step_quo;
            cnt_n = cnt + 5'd1;
            if (cnt == 5'd31) state_n = MD_DONE;
         end
         MD_DONE: state_n = MD_IDLE;
         default: state_n = MD_IDLE;
      endcase
      if (md.flushEX) begin
         state_n = MD_IDLE;
         cnt_n   = 5'd0;
      end
   end

   // Result is formed from the values about to be registered, so it lands with the DONE state.
   always_comb begin
      prod_f = neg_n ? -prod_n : prod_n;
      quo_f  = neg_n ? -quo_n : quo_n;
      rem_f  = neg_n ? -rem_n[31:0] : rem_n[31:0];
      case (op_n)
         MD_FUNCT3_MUL:                                     result_n = prod_f[31:0];
         MD_FUNCT3_MULH, MD_FUNCT3_MULHSU, MD_FUNCT3_MULHU: result_n = prod_f[63:32];
         MD_FUNCT3_DIV, MD_FUNCT3_DIVU:                     result_n = quo_f;
         default:                                           result_n = rem_f;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state    <= MD_IDLE;
         op       <= 3'd0;
         neg      <= 1'b0;
         cnt      <= 5'd0;
         opnd     <= 32'd0;
         prod     <= 64'd0;
         rem      <= 33'd0;
         quo      <= 32'd0;
         result_q <= 32'd0;
      end else begin
         state <= state_n;
         op    <= op_n;
         neg   <= neg_n;
         cnt   <= cnt_n;
         opnd  <= opnd_n;
         prod  <= prod_n;
         rem   <= rem_n;
         quo   <= quo_n;
         if (state_n == MD_DONE) result_q <= result_n;
      end
   end

   assign md.busyEX   = ((state == MD_IDLE) && md.startEX) || (state == MD_MUL) || (state == MD_DIV);
   assign md.doneEX   = (state == MD_DONE);
   assign md.resultEX = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed vector bench for ex_muldiv_unit: table of M-ops plus flush and reset sequences.
module tb_ex_muldiv_unit;

   localparam int DIV_LAT = 33;
   localparam int SPC_LAT = 1;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   logic clk;
   logic arstn;
   int   n_cmp;
   int   n_fail;

   ex_muldiv_unit_if md_if();

   ex_muldiv_unit dut (
      .clk   (clk),
      .arstn (arstn),
      .md    (md_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, required completion before 200000");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called on a falling edge; issues one op and follows it through DONE and one cycle beyond.
   task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int k;
      int busy_n;
      bit got;
      md_if.funct3EX   = f3;
      md_if.operandAEX = a;
      md_if.operandBEX = b;
      md_if.startEX    = 1'b1;
      #1;
      busy_n = md_if.busyEX ? 1 : 0;
      k   = 0;
      got = 1'b0;
      while (!got && k < 40) begin
         @(negedge clk);
         k++;
         if (md_if.doneEX) got = 1'b1;
         else if (md_if.busyEX) busy_n++;
      end
      check({name, " latency"}, 32'(k), 32'(lat));
      check({name, " result"}, md_if.resultEX, exp);
      check({name, " busy cycles"}, 32'(busy_n), 32'(lat));
      check({name, " busy at done"}, 32'(md_if.busyEX), 32'd0);
      md_if.startEX = 1'b0;
      @(negedge clk);
      check({name, " done pulse width"}, 32'(md_if.doneEX), 32'd0);
      check({name, " result held"}, md_if.resultEX, exp);
   endtask

   vec_t vecs [22];

   initial begin
      int done_n;
      int busy_n;
      n_cmp  = 0;
      n_fail = 0;

      vecs[0]  = '{"DIVU 100/7",       3'd5, 32'd100,        32'd7,          32'd14,         DIV_LAT};
      vecs[1]  = '{"REMU 100/7",       3'd7, 32'd100,        32'd7,          32'd2,          DIV_LAT};
      vecs[2]  = '{"DIV -100/7",       3'd4, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  DIV_LAT};
      vecs[3]  = '{"REM -100/7",       3'd6, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  DIV_LAT};
      vecs[4]  = '{"DIV ovf",          3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SPC_LAT};
      vecs[5]  = '{"REM ovf",          3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          SPC_LAT};
      vecs[6]  = '{"DIVU 5/0",         3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF,  SPC_LAT};
      vecs[7]  = '{"REMU 5/0",         3'd7, 32'd5,          32'd0,          32'd5,          SPC_LAT};
      vecs[8]  = '{"DIV 5/0",          3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF,  SPC_LAT};
      vecs[9]  = '{"REM -100/0",       3'd6, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FF9C,  SPC_LAT};
      vecs[10] = '{"DIVU 2^31/max",    3'd5, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          DIV_LAT};
      vecs[11] = '{"DIV 7/-2",         3'd4, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  DIV_LAT};
      vecs[12] = '{"REM 7/-2",         3'd6, 32'd7,          32'hFFFF_FFFE,  32'd1,          DIV_LAT};
      vecs[13] = '{"MULH -1*-1",       3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          MUL_LAT};
      vecs[14] = '{"MULHU max*max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  MUL_LAT};
      vecs[15] = '{"MUL 2^16*2^16",    3'd0, 32'h0001_0000,  32'h0001_0000,  32'd0,          MUL_LAT};
      vecs[16] = '{"MULHSU -1*2",      3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  MUL_LAT};
      vecs[17] = '{"MUL 7*6",          3'd0, 32'd7,          32'd6,          32'd42,         MUL_LAT};
      vecs[18] = '{"MULH min*min",     3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  MUL_LAT};
      vecs[19] = '{"MUL max*max",      3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          MUL_LAT};
      vecs[20] = '{"MULH 3*-2",        3'd1, 32'd3,          32'hFFFF_FFFE,  32'hFFFF_FFFF,  MUL_LAT};
      vecs[21] = '{"MUL 3*-2",         3'd0, 32'd3,          32'hFFFF_FFFE,  32'hFFFF_FFFA,  MUL_LAT};

      arstn            = 1'b0;
      md_if.startEX    = 1'b0;
      md_if.flushEX    = 1'b0;
      md_if.funct3EX   = 3'd0;
      md_if.operandAEX = 32'd0;
      md_if.operandBEX = 32'd0;
      #1;
      check("reset busy", 32'(md_if.busyEX), 32'd0);
      check("reset done", 32'(md_if.doneEX), 32'd0);
      check("reset result", md_if.resultEX, 32'd0);
      repeat (2) @(negedge clk);
      arstn = 1'b1;
      @(negedge clk);

      foreach (vecs[i])
         run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

      // Flush a DIVU in its 10th cycle, then restart two cycles later.
      md_if.funct3EX   = 3'd5;
      md_if.operandAEX = 32'd1000;
      md_if.operandBEX = 32'd3;
      md_if.startEX    = 1'b1;
      repeat (10) @(negedge clk);
      md_if.flushEX = 1'b1;
      md_if.startEX = 1'b0;
      @(negedge clk);
      check("flush busy", 32'(md_if.busyEX), 32'd0);
      check("flush done", 32'(md_if.doneEX), 32'd0);
      check("flush result kept", md_if.resultEX, 32'hFFFF_FFFA);
      md_if.flushEX = 1'b0;
      @(negedge clk);
      check("flush no late done", 32'(md_if.doneEX), 32'd0);
      run_op("DIVU 1000/3 after flush", 3'd5, 32'd1000, 32'd3, 32'd333, DIV_LAT);

      // Flush and start together in IDLE: the start must be dropped.
      md_if.funct3EX   = 3'd5;
      md_if.operandAEX = 32'd77;
      md_if.operandBEX = 32'd5;
      md_if.startEX    = 1'b1;
      md_if.flushEX    = 1'b1;
      @(negedge clk);
      md_if.startEX = 1'b0;
      md_if.flushEX = 1'b0;
      done_n = 0;
      busy_n = 0;
      for (int c = 0; c < 36; c++) begin
         @(negedge clk);
         if (md_if.doneEX) done_n++;
         if (md_if.busyEX) busy_n++;
      end
      check("flush priority done count", 32'(done_n), 32'd0);
      check("flush priority busy count", 32'(busy_n), 32'd0);
      check("flush priority result kept", md_if.resultEX, 32'd333);

      // Asynchronous reset in the middle of a multiply.
      md_if.funct3EX   = 3'd3;
      md_if.operandAEX = 32'hFFFF_FFFF;
      md_if.operandBEX = 32'hFFFF_FFFF;
      md_if.startEX    = 1'b1;
      repeat (5) @(negedge clk);
      md_if.startEX = 1'b0;
      arstn = 1'b0;
      #1;
      check("mid-op reset busy", 32'(md_if.busyEX), 32'd0);
      check("mid-op reset done", 32'(md_if.doneEX), 32'd0);
      check("mid-op reset result", md_if.resultEX, 32'd0);
      @(negedge clk);
      arstn = 1'b1;
      done_n = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (md_if.doneEX) done_n++;
      end
      check("post-reset no partial done", 32'(done_n), 32'd0);
      check("post-reset result", md_if.resultEX, 32'd0);
      run_op("MULHU after reset", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
